mem_arbiter: RTL and testbench

- Shares the single-port RAM between the instruction and data caches of NCPU cores.
- Sits between the per-core icache/dcache miss ports and the RAM.
- Selects one requester per transaction, drives the RAM with that requester's request, and returns completion through the per-requester wait/load lines.
- Data requests always beat instruction requests; cores are ordered round-robin or by fixed priority.

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/arb_pick.sv | 34 +++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter and its users.
//   word_t      : 32-bit machine word
//   ramstate_t  : RAM handshake state reported back to the arbiter
//   arb_state_t : arbiter FSM state
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/arb_pick.sv
// Rotating first-one picker (purely combinational).
// Ports:
//   pend  : one pending bit per core
//   ptr   : search start index; scan wraps at NCPU
//   found : at least one pending bit set
//   idx   : first pending core at or after ptr
module arb_pick
#(
  parameter int NCPU   = 2,
  parameter int CIDX_W = 1
)
(
  input  logic [NCPU-1:0]   pend,
  input  logic [CIDX_W-1:0] ptr,
  output logic              found,
  output logic [CIDX_W-1:0] idx
);

  logic [CIDX_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < NCPU; k++) begin
      cand = CIDX_W'((int'(ptr) + k) % NCPU);
      if (!found && pend[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port RAM between the icache and dcache miss
// ports of NCPU cores. Dcache requests always beat icache requests; within
// a class the core order is round-robin (ARB_RR_EN defined) or fixed
// lowest-index-first (ARB_RR_EN undefined, no pointer register).
// Ports:
//   CLK, RST                 : clock, synchronous active-high reset
//   iREN/iaddr -> iwait/iload : per-core icache request / completion
//   dREN/dWEN/daddr/dstore -> dwait/dload : per-core dcache request / completion
//   ramREN/ramWEN/ramaddr/ramstore, ramload/ramstate : RAM side
//
// state | meaning
// IDLE  | no owner; RAM idle; pick the next winner from pending requests
// GRANT | owner's live request drives the RAM until ACCESS or abort
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NCPU   = 2,
  parameter int CIDX_W = 1
)
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NCPU-1:0]       iREN,
  input  word_t [NCPU-1:0]      iaddr,
  output logic [NCPU-1:0]       iwait,
  output word_t [NCPU-1:0]      iload,
  input  logic [NCPU-1:0]       dREN,
  input  logic [NCPU-1:0]       dWEN,
  input  word_t [NCPU-1:0]      daddr,
  input  word_t [NCPU-1:0]      dstore,
  output logic [NCPU-1:0]       dwait,
  output word_t [NCPU-1:0]      dload,
  output logic                  ramREN,
  output logic                  ramWEN,
  output word_t                 ramaddr,
  output word_t                 ramstore,
  input  word_t                 ramload,
  input  ramstate_t             ramstate
);

  arb_state_t        state_q, state_d;
  logic [CIDX_W-1:0] owner_q, owner_d;
  logic              own_d_q, own_d_d;   // 1: owner is the dcache port
  logic [CIDX_W-1:0] ptr;
  logic              d_found, i_found;
  logic [CIDX_W-1:0] d_idx, i_idx;
  logic              req_live;
  logic              done;

  arb_pick #(.NCPU(NCPU), .CIDX_W(CIDX_W)) u_pick_d (
    .pend  (dREN | dWEN),
    .ptr   (ptr),
    .found (d_found),
    .idx   (d_idx)
  );

  arb_pick #(.NCPU(NCPU), .CIDX_W(CIDX_W)) u_pick_i (
    .pend  (iREN),
    .ptr   (ptr),
    .found (i_found),
    .idx   (i_idx)
  );

`ifdef ARB_RR_EN
  logic [CIDX_W-1:0] ptr_q, ptr_d, owner_inc;

  always_comb begin
    owner_inc = (int'(owner_q) == NCPU - 1) ? '0 : owner_q + 1'b1;
    ptr_d     = done ? owner_inc : ptr_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    own_d_d  = own_d_q;
    iwait    = '1;
    dwait    = '1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    req_live = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_found) begin
          owner_d = d_idx;
          own_d_d = 1'b1;
          state_d = GRANT;
        end else if (i_found) begin
          owner_d = i_idx;
          own_d_d = 1'b0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        req_live = own_d_q ? (dREN[owner_q] | dWEN[owner_q]) : iREN[owner_q];
        if (!req_live) begin
          // Owner withdrew before ACCESS: drop without a wait pulse.
          state_d = IDLE;
        end else begin
          if (own_d_q) begin
            // Read+write together counts as a write.
            ramWEN   = dWEN[owner_q];
            ramREN   = dREN[owner_q] & ~dWEN[owner_q];
            ramaddr  = daddr[owner_q];
            ramstore = dstore[owner_q];
          end else begin
            ramREN   = 1'b1;
            ramaddr  = iaddr[owner_q];
          end
          // A reset landing on the ACCESS cycle discards the transaction.
          if (ramstate == ACCESS && !RST) begin
            done    = 1'b1;
            state_d = IDLE;
            if (own_d_q) begin
              dwait[owner_q] = 1'b0;
              if (!dWEN[owner_q]) dload[owner_q] = ramload;
            end else begin
              iwait[owner_q] = 1'b0;
              iload[owner_q] = ramload;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      owner_q <= '0;
      own_d_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      own_d_q <= own_d_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (NCPU=2). Build with or without
// ARB_RR_EN; the round-robin expectations follow the same macro.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam word_t KEY = 32'h5A5A_5A5A;   // RAM model: read data = addr ^ KEY

  logic        CLK, RST;
  logic [1:0]  iREN, iwait, dREN, dWEN, dwait;
  word_t [1:0] iaddr, iload, daddr, dstore, dload;
  logic        ramREN, ramWEN;
  word_t       ramaddr, ramstore, ramload;
  ramstate_t   ramstate;

  mem_arbiter #(.NCPU(2), .CIDX_W(1)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  typedef struct {
    bit    is_d;
    int    core;
    bit    wen;
    word_t addr;
    word_t store;
    word_t load;
  } exp_t;

  typedef struct {
    bit    is_d;
    bit    ren;
    bit    wen;
    int    core;
    word_t addr;
    word_t store;
    int    lat;
    bit    err;
    word_t exp_load;
  } vec_t;

  exp_t  sb[$];
  vec_t  vec[7];
  int    cnt_cmp = 0, cnt_bad = 0, pulse_cnt = 0;
  bit    mon_en = 0, new_pulse = 0, last_d = 0;
  int    last_c = 0;
  int    ram_cnt = 0, ram_lat = 0;
  bit    ram_err = 0, ram_ovr_en = 0;
  word_t ram_ovr = '0;
  int    cyc;
  int    order[4];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    cnt_cmp++;
    if (act !== exp) begin
      cnt_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ram_model();
    if (ramREN || ramWEN) begin
      if (ram_cnt >= ram_lat) ramstate = ACCESS;
      else                    ramstate = ram_err ? ERROR : BUSY;
      ram_cnt++;
    end else begin
      ramstate = FREE;
      ram_cnt  = 0;
    end
    ramload = ram_ovr_en ? ram_ovr : (ramaddr ^ KEY);
  endtask

  task automatic monitor();
    int          nz;
    exp_t        e;
    logic [1:0]  ew_i, ew_d;
    word_t [1:0] el_i, el_d;
    if (!mon_en) return;
    nz = $countones(~iwait) + $countones(~dwait);
    if (nz == 0) begin
      chk("idle_loads", 128'({iload, dload}), 128'(0));
    end else begin
      chk("one_wait", 128'(nz), 128'(1));
      pulse_cnt++;
      new_pulse = 1'b1;
      for (int c = 0; c < 2; c++) begin
        if (!iwait[c]) begin last_d = 1'b0; last_c = c; end
        if (!dwait[c]) begin last_d = 1'b1; last_c = c; end
      end
      if (sb.size() == 0) begin
        cnt_cmp++;
        cnt_bad++;
        $display("FAIL unexpected_pulse: actual iwait=%b dwait=%b required=no pulse at %0t",
                 iwait, dwait, $time);
      end else begin
        e    = sb.pop_front();
        ew_i = '1; ew_d = '1; el_i = '0; el_d = '0;
        if (e.is_d) begin ew_d[e.core] = 1'b0; el_d[e.core] = e.load; end
        else        begin ew_i[e.core] = 1'b0; el_i[e.core] = e.load; end
        chk("waits", 128'({iwait, dwait}), 128'({ew_i, ew_d}));
        chk("loads", 128'({iload, dload}), 128'({el_i, el_d}));
        chk("ram_en", 128'({ramREN, ramWEN}), 128'({~e.wen, e.wen}));
        chk("ram_addr", 128'(ramaddr), 128'(e.addr));
        if (e.wen) chk("ram_store", 128'(ramstore), 128'(e.store));
      end
    end
  endtask

  task automatic half();
    #1 ram_model();
    #1 monitor();
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_req(input bit is_d, input int c);
    if (is_d) begin dREN[c] = 1'b0; dWEN[c] = 1'b0; end
    else      iREN[c] = 1'b0;
  endtask

  task automatic run_pulses(input int n, input bit hold, input int budget, output int cycles);
    int target;
    target = pulse_cnt + n;
    cycles = 0;
    while (pulse_cnt < target && cycles < budget) begin
      new_pulse = 1'b0;
      half();
      adv();
      cycles++;
      if (new_pulse && !hold) clear_req(last_d, last_c);
    end
    chk("pulse_count", 128'(pulse_cnt), 128'(target));
  endtask

  initial begin
    //        is_d ren wen core addr           store          lat err exp_load
    vec[0] = '{1'b0, 1'b1, 1'b0, 0, 32'h0000_0040, 32'h0,         0, 1'b0, 32'h5A5A_5A1A};
    vec[1] = '{1'b0, 1'b1, 1'b0, 1, 32'h0000_0100, 32'h0,         1, 1'b0, 32'h5A5A_5B5A};
    vec[2] = '{1'b1, 1'b1, 1'b0, 0, 32'h0000_0200, 32'h0,         2, 1'b0, 32'h5A5A_585A};
    vec[3] = '{1'b1, 1'b0, 1'b1, 1, 32'h0000_0300, 32'hCAFE_F00D, 0, 1'b0, 32'h0};
    vec[4] = '{1'b1, 1'b1, 1'b1, 0, 32'h0000_0400, 32'h1122_3344, 1, 1'b0, 32'h0};
    vec[5] = '{1'b1, 1'b1, 1'b0, 1, 32'hFFFF_FFFC, 32'h0,         3, 1'b1, 32'hA5A5_A5A6};
    vec[6] = '{1'b0, 1'b1, 1'b0, 0, 32'h1234_5678, 32'h0,         0, 1'b0, 32'h486E_0C22};

    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;

    // Reset for two edges, then check the reset outputs.
    RST = 1'b1;
    adv();
    adv();
    RST = 1'b0;
    half();
    chk("rst_waits", 128'({iwait, dwait}), 128'(4'hF));
    chk("rst_loads", 128'({iload, dload}), 128'(0));
    chk("rst_ram", 128'({ramREN, ramWEN, ramaddr, ramstore}), 128'(0));
    mon_en = 1'b1;
    adv();

    // Single icache read, ACCESS two cycles after ramREN.
    iREN[0] = 1'b1; iaddr[0] = 32'h40;
    ram_lat = 2; ram_ovr_en = 1'b1; ram_ovr = 32'hDEAD_BEEF;
    sb.push_back('{1'b0, 0, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF});
    half();
    chk("t1_ren_n", 128'(ramREN), 128'(0));
    adv();
    half();
    chk("t1_ren_n1", 128'({ramREN, ramaddr}), 128'({1'b1, 32'h40}));
    chk("t1_wait_n1", 128'(iwait), 128'(2'b11));
    adv();
    half();
    adv();
    half();
    chk("t1_pulse", 128'(pulse_cnt), 128'(1));
    adv();
    iREN[0] = 1'b0;
    half();
    chk("t1_one_cycle", 128'({iwait, dwait, ramREN}), 128'({4'hF, 1'b0}));
    adv();
    ram_ovr_en = 1'b0;

    // Table of single transactions.
    for (int i = 0; i < 7; i++) begin
      if (vec[i].is_d) begin
        dREN[vec[i].core]   = vec[i].ren;
        dWEN[vec[i].core]   = vec[i].wen;
        daddr[vec[i].core]  = vec[i].addr;
        dstore[vec[i].core] = vec[i].store;
      end else begin
        iREN[vec[i].core]  = 1'b1;
        iaddr[vec[i].core] = vec[i].addr;
      end
      ram_lat = vec[i].lat;
      ram_err = vec[i].err;
      sb.push_back('{vec[i].is_d, vec[i].core, vec[i].is_d & vec[i].wen,
                     vec[i].addr, vec[i].store, vec[i].exp_load});
      run_pulses(1, 1'b0, 30, cyc);
      chk("latency", 128'(cyc), 128'(vec[i].lat + 2));
      half();
      adv();
    end
    ram_err = 1'b0;

    // Dcache write beats icache read issued in the same cycle.
    ram_lat = 0;
    iREN[0] = 1'b1; iaddr[0] = 32'h100;
    dWEN[1] = 1'b1; daddr[1] = 32'h200; dstore[1] = 32'h1234_5678;
    sb.push_back('{1'b1, 1, 1'b1, 32'h200, 32'h1234_5678, 32'h0});
    sb.push_back('{1'b0, 0, 1'b0, 32'h100, 32'h0, 32'h100 ^ KEY});
    run_pulses(2, 1'b0, 40, cyc);
    chk("back_to_back", 128'(cyc), 128'(4));
    half();
    adv();

    // Abort: icache core 1 withdraws while in GRANT.
    ram_lat = 5;
    iREN[1] = 1'b1; iaddr[1] = 32'h500;
    half();
    adv();
    half();
    chk("abort_en", 128'({ramREN, ramaddr}), 128'({1'b1, 32'h500}));
    adv();
    iREN[1] = 1'b0;
    half();
    chk("abort_drop", 128'({ramREN, iwait[1]}), 128'(2'b01));
    adv();
    half();
    chk("abort_idle", 128'({ramREN, ramWEN, iwait, dwait}), 128'(6'b00_1111));
    adv();
    ram_lat = 0;
    iREN[0] = 1'b1; iaddr[0] = 32'h600;
    sb.push_back('{1'b0, 0, 1'b0, 32'h600, 32'h0, 32'h600 ^ KEY});
    run_pulses(1, 1'b0, 30, cyc);
    chk("abort_recover", 128'(cyc), 128'(2));
    half();
    adv();

    // Reset while in GRANT.
    ram_lat = 10;
    iREN[1] = 1'b1; iaddr[1] = 32'h700;
    half();
    adv();
    half();
    chk("rst_pre_en", 128'(ramREN), 128'(1));
    adv();
    RST = 1'b1;
    half();
    adv();
    half();
    chk("rst_mid_en", 128'({ramREN, ramWEN}), 128'(0));
    chk("rst_mid_waits", 128'({iwait, dwait}), 128'(4'hF));
    RST = 1'b0;
    iREN[1] = 1'b0;
    adv();
    half();
    adv();

    // Both dcaches hold requests for four grants.
`ifdef ARB_RR_EN
    order = '{0, 1, 0, 1};
`else
    order = '{0, 0, 0, 0};
`endif
    ram_lat = 0;
    daddr[0] = 32'h1000; daddr[1] = 32'h1010;
    dREN = 2'b11;
    for (int k = 0; k < 4; k++)
      sb.push_back('{1'b1, order[k], 1'b0, (order[k] == 1) ? 32'h1010 : 32'h1000,
                     32'h0, ((order[k] == 1) ? 32'h1010 : 32'h1000) ^ KEY});
    run_pulses(4, 1'b1, 60, cyc);
    dREN = 2'b00;
    for (int k = 0; k < 3; k++) begin
      half();
      adv();
    end

    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_bad);
    $finish;
  end

endmodule
